// File: rtl/rat_multi_ckp_if.sv
// Rename-stage bundle for rat_multi_ckp: rename group, lookups, checkpoint IDs and branch-unit restore/release.
// The master is decode plus the branch unit; the slave is the alias table.
interface rat_multi_ckp_if #(
    parameter int P_ADDR_WIDTH = 7,
    parameter int L_ADDR_WIDTH = 5,
    parameter int RN_W         = 2,
    parameter int C_NUM        = 4
);
    localparam int CW = $clog2(C_NUM);

    logic                                     rn_valid;
    logic                                     rn_ready;
    logic [RN_W-1:0]                          wr_en;
    logic [RN_W-1:0][L_ADDR_WIDTH-1:0]        wr_addr;
    logic [RN_W-1:0][P_ADDR_WIDTH-1:0]        wr_data;
    logic [RN_W-1:0]                          ckp_req;
    logic [RN_W-1:0][CW-1:0]                  ckp_id;
    logic [RN_W-1:0][L_ADDR_WIDTH-1:0]        rs1_addr;
    logic [RN_W-1:0][L_ADDR_WIDTH-1:0]        rs2_addr;
    logic [RN_W-1:0][L_ADDR_WIDTH-1:0]        rd_addr;
    logic [RN_W-1:0][P_ADDR_WIDTH-1:0]        rs1_data;
    logic [RN_W-1:0][P_ADDR_WIDTH-1:0]        rs2_data;
    logic [RN_W-1:0][P_ADDR_WIDTH-1:0]        rd_old;
    logic                                     release_valid;
    logic                                     restore_valid;
    logic [CW-1:0]                            restore_id;
    logic [CW:0]                              ckp_free_cnt;

    modport master (
        output rn_valid, wr_en, wr_addr, wr_data, ckp_req,
        output rs1_addr, rs2_addr, rd_addr,
        output release_valid, restore_valid, restore_id,
        input  rn_ready, ckp_id, rs1_data, rs2_data, rd_old, ckp_free_cnt
    );

    modport slave (
        input  rn_valid, wr_en, wr_addr, wr_data, ckp_req,
        input  rs1_addr, rs2_addr, rd_addr,
        input  release_valid, restore_valid, restore_id,
        output rn_ready, ckp_id, rs1_data, rs2_data, rd_old, ckp_free_cnt
    );
endinterface

// File: rtl/rat_multi_ckp.sv
// Multi-slot register alias table with a circular pool of C_NUM checkpoints (allocate/release/restore).
// Optional macro RAT_INTRA_BYPASS_EN forwards earlier-slot destinations of the same group to later-slot reads.
module rat_multi_ckp #(
    parameter int P_ADDR_WIDTH = 7,
    parameter int L_ADDR_WIDTH = 5,
    parameter int RN_W         = 2,
    parameter int C_NUM        = 4,
    parameter int RESET_BASE   = 8
) (
    input  logic               clk,
    input  logic               rst,
    rat_multi_ckp_if.slave     bus
);
    localparam int L_REGS = 2**L_ADDR_WIDTH;
    localparam int CW     = $clog2(C_NUM);
    localparam int SW     = CW + 4;

    typedef logic [L_REGS-1:0][P_ADDR_WIDTH-1:0] rat_t;

    rat_t                              r_cur_rat;
    rat_t                              r_ckp_rat [C_NUM];
    logic [CW-1:0]                     r_head;
    logic [CW-1:0]                     r_tail;
    logic [CW:0]                       r_count;

    logic [SW-1:0]                     w_req_cnt;
    logic [SW-1:0]                     w_free;
    logic                              w_ready;
    logic                              w_accept;
    logic                              w_release;
    logic [CW-1:0]                     w_head_nxt;
    logic [RN_W-1:0][CW-1:0]           w_ckp_id;
    rat_t                              w_stage [RN_W];
    logic [RN_W-1:0][P_ADDR_WIDTH-1:0] w_rs1_data;
    logic [RN_W-1:0][P_ADDR_WIDTH-1:0] w_rs2_data;
    logic [RN_W-1:0][P_ADDR_WIDTH-1:0] w_rd_old;

    function automatic logic [SW-1:0] popcount(input logic [RN_W-1:0] v);
        logic [SW-1:0] n;
        n = '0;
        for (int i = 0; i < RN_W; i++) n = n + SW'(v[i]);
        return n;
    endfunction

    assign w_req_cnt  = popcount(bus.ckp_req);
    assign w_free     = SW'(C_NUM) - SW'(r_count);
    assign w_ready    = (w_free >= w_req_cnt) && !bus.restore_valid;
    assign w_accept   = bus.rn_valid && w_ready;
    assign w_release  = bus.release_valid && (r_count != '0);
    assign w_head_nxt = r_head + CW'(w_release);

    assign bus.rn_ready     = w_ready;
    assign bus.ckp_free_cnt = w_free[CW:0];
    assign bus.ckp_id       = w_ckp_id;
    assign bus.rs1_data     = w_rs1_data;
    assign bus.rs2_data     = w_rs2_data;
    assign bus.rd_old       = w_rd_old;

    // Requesting slots take consecutive IDs starting at tail, in slot order.
    always_comb begin
        logic [CW-1:0] v_ofs;
        v_ofs = '0;
        for (int s = 0; s < RN_W; s++) begin
            w_ckp_id[s] = r_tail + v_ofs;
            if (bus.ckp_req[s]) v_ofs = v_ofs + CW'(1);
        end
    end

    // w_stage[s] is the table after the writes of slots 0..s; it is both the snapshot for slot s and the next table.
    always_comb begin
        rat_t v_rat;
        v_rat = r_cur_rat;
        for (int s = 0; s < RN_W; s++) begin
            if (bus.wr_en[s]) v_rat[bus.wr_addr[s]] = bus.wr_data[s];
            w_stage[s] = v_rat;
        end
    end

    always_comb begin
        for (int s = 0; s < RN_W; s++) begin
            w_rs1_data[s] = r_cur_rat[bus.rs1_addr[s]];
            w_rs2_data[s] = r_cur_rat[bus.rs2_addr[s]];
            w_rd_old[s]   = r_cur_rat[bus.rd_addr[s]];
`ifdef RAT_INTRA_BYPASS_EN
            if (bus.rn_valid) begin
                for (int t = 0; t < s; t++) begin
                    if (bus.wr_en[t] && bus.wr_addr[t] == bus.rs1_addr[s]) w_rs1_data[s] = bus.wr_data[t];
                    if (bus.wr_en[t] && bus.wr_addr[t] == bus.rs2_addr[s]) w_rs2_data[s] = bus.wr_data[t];
                    if (bus.wr_en[t] && bus.wr_addr[t] == bus.rd_addr[s])  w_rd_old[s]   = bus.wr_data[t];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L_REGS; i++) r_cur_rat[i] <= P_ADDR_WIDTH'(RESET_BASE + i);
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head <= w_head_nxt;
            if (bus.restore_valid) begin
                // Live IDs become head'..restore_id; everything younger is discarded.
                r_cur_rat <= r_ckp_rat[bus.restore_id];
                r_tail    <= bus.restore_id + CW'(1);
                r_count   <= {1'b0, bus.restore_id - w_head_nxt} + (CW+1)'(1);
            end else if (w_accept) begin
                r_cur_rat <= w_stage[RN_W-1];
                r_tail    <= r_tail + w_req_cnt[CW-1:0];
                r_count   <= r_count + w_req_cnt[CW:0] - (CW+1)'(w_release);
            end else begin
                r_count   <= r_count - (CW+1)'(w_release);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            for (int s = 0; s < RN_W; s++) begin
                if (bus.ckp_req[s]) r_ckp_rat[w_ckp_id[s]] <= w_stage[s];
            end
        end
    end
endmodule

// File: tb/tb_rat_multi_ckp.sv
// Self-checking bench for rat_multi_ckp: directed scenarios plus randomized traffic against a queue-based model.
// Honours RAT_INTRA_BYPASS_EN the same way as the design build.
module tb_rat_multi_ckp;
    localparam int P      = 7;
    localparam int L      = 5;
    localparam int RN_W   = 2;
    localparam int C_NUM  = 4;
    localparam int RB     = 8;
    localparam int L_REGS = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rat_multi_ckp_if #(.P_ADDR_WIDTH(P), .L_ADDR_WIDTH(L), .RN_W(RN_W), .C_NUM(C_NUM)) bus();

    rat_multi_ckp #(.P_ADDR_WIDTH(P), .L_ADDR_WIDTH(L), .RN_W(RN_W), .C_NUM(C_NUM), .RESET_BASE(RB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: current map, stored snapshots, live IDs oldest-first, next ID to hand out.
    int mrat [L_REGS];
    int mckp [C_NUM][L_REGS];
    int q [$];
    int next_id;

    task automatic idle();
        rst = 1'b0;
        bus.rn_valid = 1'b0;
        bus.wr_en = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.ckp_req = '0;
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        bus.rd_addr = '0;
        bus.release_valid = 1'b0;
        bus.restore_valid = 1'b0;
        bus.restore_id = '0;
    endtask

    task automatic model_step();
        int  rid;
        bit  ready;
        if (rst) begin
            for (int i = 0; i < L_REGS; i++) mrat[i] = RB + i;
            q.delete();
            next_id = 0;
            return;
        end
        ready = ((C_NUM - q.size()) >= $countones(bus.ckp_req)) && !bus.restore_valid;
        if (bus.release_valid && q.size() > 0) void'(q.pop_front());
        if (bus.restore_valid) begin
            rid = int'(bus.restore_id);
            for (int i = 0; i < L_REGS; i++) mrat[i] = mckp[rid][i];
            while (q.size() > 0 && q[$] != rid) void'(q.pop_back());
            next_id = (rid + 1) % C_NUM;
        end else if (bus.rn_valid && ready) begin
            for (int s = 0; s < RN_W; s++) begin
                if (bus.wr_en[s]) mrat[int'(bus.wr_addr[s])] = int'(bus.wr_data[s]);
                if (bus.ckp_req[s]) begin
                    for (int i = 0; i < L_REGS; i++) mckp[next_id][i] = mrat[i];
                    q.push_back(next_id);
                    next_id = (next_id + 1) % C_NUM;
                end
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        idle();
    endtask

    function automatic int exp_read(int s, int a);
        int e;
        e = mrat[a];
`ifdef RAT_INTRA_BYPASS_EN
        if (bus.rn_valid)
            for (int t = 0; t < s; t++)
                if (bus.wr_en[t] && int'(bus.wr_addr[t]) == a) e = int'(bus.wr_data[t]);
`endif
        return e;
    endfunction

    task automatic test_reset();
        do_reset();
        bus.rs1_addr[0] = 5'd0;
        bus.rs2_addr[1] = 5'd31;
        bus.rd_addr[1]  = 5'd5;
        #1;
        checks++; if (bus.rs1_data[0] !== 7'd8) begin errors++; $display("FAIL reset_lreg0: got %0d expected 8", bus.rs1_data[0]); end
        checks++; if (bus.rs2_data[1] !== 7'd39) begin errors++; $display("FAIL reset_lreg31: got %0d expected 39", bus.rs2_data[1]); end
        checks++; if (bus.rd_old[1] !== 7'd13) begin errors++; $display("FAIL reset_lreg5: got %0d expected 13", bus.rd_old[1]); end
        checks++; if (bus.ckp_free_cnt !== 3'd4) begin errors++; $display("FAIL reset_free: got %0d expected 4", bus.ckp_free_cnt); end
        checks++; if (bus.rn_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", bus.rn_ready); end
    endtask

    task automatic test_slot_ckp(input bit slot1);
        int r5_exp;
        do_reset();
        bus.rn_valid = 1'b1;
        bus.wr_en = 2'b11;
        bus.wr_addr[0] = 5'd3;  bus.wr_data[0] = 7'd40;
        bus.wr_addr[1] = 5'd5;  bus.wr_data[1] = 7'd41;
        bus.ckp_req = slot1 ? 2'b10 : 2'b01;
        #1;
        checks++; if (bus.ckp_id[slot1] !== 2'd0) begin errors++; $display("FAIL ckp_id_slot%0d: got %0d expected 0", slot1, bus.ckp_id[slot1]); end
        step();
        idle();
        bus.rd_addr[1] = 5'd5;
        #1;
        checks++; if (bus.rd_old[1] !== 7'd41) begin errors++; $display("FAIL written_r5: got %0d expected 41", bus.rd_old[1]); end
        checks++; if (bus.ckp_free_cnt !== 3'd3) begin errors++; $display("FAIL free_after_alloc: got %0d expected 3", bus.ckp_free_cnt); end
        bus.restore_valid = 1'b1;
        bus.restore_id = 2'd0;
        #1;
        checks++; if (bus.rn_ready !== 1'b0) begin errors++; $display("FAIL ready_during_restore: got %0b expected 0", bus.rn_ready); end
        step();
        idle();
        bus.rs1_addr[0] = 5'd3;
        bus.rs2_addr[0] = 5'd5;
        #1;
        r5_exp = slot1 ? 41 : RB + 5;
        checks++; if (bus.rs1_data[0] !== 7'd40) begin errors++; $display("FAIL restore_r3_s%0d: got %0d expected 40", slot1, bus.rs1_data[0]); end
        checks++; if (bus.rs2_data[0] !== P'(r5_exp)) begin errors++; $display("FAIL restore_r5_s%0d: got %0d expected %0d", slot1, bus.rs2_data[0], r5_exp); end
        checks++; if (bus.ckp_free_cnt !== 3'd3) begin errors++; $display("FAIL free_after_restore: got %0d expected 3", bus.ckp_free_cnt); end
    endtask

    task automatic test_collision();
        int e1;
        do_reset();
        bus.rn_valid = 1'b1;
        bus.wr_en = 2'b11;
        bus.wr_addr[0] = 5'd7;  bus.wr_data[0] = 7'd50;
        bus.wr_addr[1] = 5'd7;  bus.wr_data[1] = 7'd51;
        bus.rs1_addr[0] = 5'd7;
        bus.rs1_addr[1] = 5'd7;
        #1;
`ifdef RAT_INTRA_BYPASS_EN
        e1 = 50;
`else
        e1 = 15;
`endif
        checks++; if (bus.rs1_data[0] !== 7'd15) begin errors++; $display("FAIL coll_slot0_read: got %0d expected 15", bus.rs1_data[0]); end
        checks++; if (bus.rs1_data[1] !== P'(e1)) begin errors++; $display("FAIL coll_slot1_read: got %0d expected %0d", bus.rs1_data[1], e1); end
        step();
        idle();
        bus.rs1_addr[0] = 5'd7;
        #1;
        checks++; if (bus.rs1_data[0] !== 7'd51) begin errors++; $display("FAIL coll_winner: got %0d expected 51", bus.rs1_data[0]); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int g = 0; g < 2; g++) begin
            bus.rn_valid = 1'b1;
            bus.ckp_req = 2'b11;
            #1;
            checks++; if (bus.ckp_id[0] !== 2'(2*g)) begin errors++; $display("FAIL fill_id0_g%0d: got %0d expected %0d", g, bus.ckp_id[0], 2*g); end
            checks++; if (bus.ckp_id[1] !== 2'(2*g+1)) begin errors++; $display("FAIL fill_id1_g%0d: got %0d expected %0d", g, bus.ckp_id[1], 2*g+1); end
            step();
        end
        idle();
        #1;
        checks++; if (bus.ckp_free_cnt !== 3'd0) begin errors++; $display("FAIL full_free: got %0d expected 0", bus.ckp_free_cnt); end
        bus.rn_valid = 1'b1;
        bus.ckp_req = 2'b01;
        #1;
        checks++; if (bus.rn_ready !== 1'b0) begin errors++; $display("FAIL full_ready_req: got %0b expected 0", bus.rn_ready); end
        bus.ckp_req = 2'b00;
        #1;
        checks++; if (bus.rn_ready !== 1'b1) begin errors++; $display("FAIL full_ready_noreq: got %0b expected 1", bus.rn_ready); end
        idle();
        bus.release_valid = 1'b1;
        step();
        step();
        idle();
        #1;
        checks++; if (bus.ckp_free_cnt !== 3'd2) begin errors++; $display("FAIL free_after_release: got %0d expected 2", bus.ckp_free_cnt); end
        bus.rn_valid = 1'b1;
        bus.ckp_req = 2'b11;
        #1;
        checks++; if (bus.ckp_id[0] !== 2'd0) begin errors++; $display("FAIL wrap_id0: got %0d expected 0", bus.ckp_id[0]); end
        checks++; if (bus.ckp_id[1] !== 2'd1) begin errors++; $display("FAIL wrap_id1: got %0d expected 1", bus.ckp_id[1]); end
        checks++; if (bus.rn_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %0b expected 1", bus.rn_ready); end
        step();
        idle();
        #1;
        checks++; if (bus.ckp_free_cnt !== 3'd0) begin errors++; $display("FAIL wrap_free: got %0d expected 0", bus.ckp_free_cnt); end
    endtask

    task automatic test_restore_release();
        do_reset();
        bus.rn_valid = 1'b1;
        bus.wr_en = 2'b11;
        bus.ckp_req = 2'b11;
        bus.wr_addr[0] = 5'd1;  bus.wr_data[0] = 7'd60;
        bus.wr_addr[1] = 5'd2;  bus.wr_data[1] = 7'd61;
        step();
        bus.wr_data[0] = 7'd62;
        bus.wr_data[1] = 7'd63;
        step();
        idle();
        bus.release_valid = 1'b1;
        step();
        idle();
        #1;
        checks++; if (bus.ckp_free_cnt !== 3'd1) begin errors++; $display("FAIL rr_setup_free: got %0d expected 1", bus.ckp_free_cnt); end
        bus.release_valid = 1'b1;
        bus.restore_valid = 1'b1;
        bus.restore_id = 2'd2;
        bus.rn_valid = 1'b1;
        bus.wr_en = 2'b01;
        bus.wr_addr[0] = 5'd9;  bus.wr_data[0] = 7'd99;
        bus.ckp_req = 2'b01;
        #1;
        checks++; if (bus.rn_ready !== 1'b0) begin errors++; $display("FAIL rr_ready: got %0b expected 0", bus.rn_ready); end
        step();
        idle();
        bus.rs1_addr[0] = 5'd1;
        bus.rs2_addr[0] = 5'd2;
        bus.rd_addr[0]  = 5'd9;
        bus.ckp_req = 2'b01;
        #1;
        checks++; if (bus.rs1_data[0] !== 7'd62) begin errors++; $display("FAIL rr_r1: got %0d expected 62", bus.rs1_data[0]); end
        checks++; if (bus.rs2_data[0] !== 7'd61) begin errors++; $display("FAIL rr_r2: got %0d expected 61", bus.rs2_data[0]); end
        checks++; if (bus.rd_old[0] !== 7'd17) begin errors++; $display("FAIL rr_r9_not_written: got %0d expected 17", bus.rd_old[0]); end
        checks++; if (bus.ckp_free_cnt !== 3'd3) begin errors++; $display("FAIL rr_free: got %0d expected 3", bus.ckp_free_cnt); end
        checks++; if (bus.ckp_id[0] !== 2'd3) begin errors++; $display("FAIL rr_tail: got %0d expected 3", bus.ckp_id[0]); end
        for (int k = 0; k < 2; k++) begin
            bus.release_valid = 1'b1;
            step();
            bus.release_valid = 1'b0;
            #1;
            checks++; if (bus.ckp_free_cnt !== 3'd4) begin errors++; $display("FAIL release_to_empty_%0d: got %0d expected 4", k, bus.ckp_free_cnt); end
        end
        checks++; if (bus.ckp_id[0] !== 2'd3) begin errors++; $display("FAIL empty_release_tail: got %0d expected 3", bus.ckp_id[0]); end
        idle();
    endtask

    task automatic test_random();
        int k, base, idx, e;
        bit exp_ready;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle();
            rst = ($urandom_range(0, 99) == 0);
            bus.rn_valid = ($urandom_range(0, 3) != 0);
            for (int s = 0; s < RN_W; s++) begin
                bus.wr_en[s]    = $urandom_range(0, 1) == 1;
                bus.wr_addr[s]  = 5'($urandom_range(0, 7));
                bus.wr_data[s]  = 7'($urandom_range(0, 127));
                bus.ckp_req[s]  = ($urandom_range(0, 9) < 3);
                bus.rs1_addr[s] = 5'($urandom_range(0, 7));
                bus.rs2_addr[s] = 5'($urandom_range(0, 31));
                bus.rd_addr[s]  = 5'($urandom_range(0, 7));
            end
            bus.release_valid = ($urandom_range(0, 3) == 0);
            base = (bus.release_valid && q.size() > 0) ? 1 : 0;
            if (q.size() > base && $urandom_range(0, 9) == 0) begin
                idx = int'($urandom_range(base, q.size() - 1));
                bus.restore_valid = 1'b1;
                bus.restore_id = 2'(q[idx]);
            end
            #1;
            exp_ready = ((C_NUM - q.size()) >= $countones(bus.ckp_req)) && !bus.restore_valid;
            checks++; if (bus.rn_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %0b expected %0b", cyc, bus.rn_ready, exp_ready); end
            checks++; if (bus.ckp_free_cnt !== 3'(C_NUM - q.size())) begin errors++; $display("FAIL rnd_free c%0d: got %0d expected %0d", cyc, bus.ckp_free_cnt, C_NUM - q.size()); end
            k = 0;
            for (int s = 0; s < RN_W; s++) begin
                if (bus.ckp_req[s]) begin
                    checks++; if (bus.ckp_id[s] !== 2'((next_id + k) % C_NUM)) begin errors++; $display("FAIL rnd_ckp_id c%0d s%0d: got %0d expected %0d", cyc, s, bus.ckp_id[s], (next_id + k) % C_NUM); end
                    k++;
                end
                e = exp_read(s, int'(bus.rs1_addr[s]));
                checks++; if (bus.rs1_data[s] !== P'(e)) begin errors++; $display("FAIL rnd_rs1 c%0d s%0d: got %0d expected %0d", cyc, s, bus.rs1_data[s], e); end
                e = exp_read(s, int'(bus.rs2_addr[s]));
                checks++; if (bus.rs2_data[s] !== P'(e)) begin errors++; $display("FAIL rnd_rs2 c%0d s%0d: got %0d expected %0d", cyc, s, bus.rs2_data[s], e); end
                e = exp_read(s, int'(bus.rd_addr[s]));
                checks++; if (bus.rd_old[s] !== P'(e)) begin errors++; $display("FAIL rnd_rd c%0d s%0d: got %0d expected %0d", cyc, s, bus.rd_old[s], e); end
            end
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_slot_ckp(1'b1);
        test_slot_ckp(1'b0);
        test_collision();
        test_full_wrap();
        test_restore_release();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
